// File: rtl/frame_sync_detect.sv
// Serial frame synchroniser: hunts for a header, collects payload plus checksum, verifies the mod-256 sum.
// Optional FRAME_SYNC_STATS_EN adds saturating good/error frame counters.
module frame_sync_detect #(
  parameter int unsigned        HDR_W       = 8,
  parameter logic [HDR_W-1:0]   HEADER      = 8'hCC,
  parameter int unsigned        PLD_BYTES   = 3,
  parameter int unsigned        TIMEOUT_CYC = 64,
  localparam int unsigned       FRAME_W     = HDR_W + 8*PLD_BYTES + 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ser_i,
  input  logic               sync_flag,
  output logic               header_flag,
  output logic               valid_flag,
  output logic               chk_err,
  output logic               timeout_flag,
`ifdef FRAME_SYNC_STATS_EN
  output logic [15:0]        good_cnt,
  output logic [15:0]        err_cnt,
`endif
  output logic [FRAME_W-1:0] valid_data_o
);

  localparam int unsigned PLD_W  = 8*PLD_BYTES;
  localparam int unsigned BODY_W = PLD_W + 8;
  localparam int unsigned FILL_W = $clog2(HDR_W + 1);
  localparam int unsigned BCNT_W = $clog2(BODY_W + 1);
  localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Header bytes are part of the checksum, so their sum seeds the accumulator.
  function automatic logic [7:0] byte_sum(input logic [HDR_W-1:0] h);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < int'(HDR_W/8); i++) s = s + h[i*8 +: 8];
    return s;
  endfunction

  localparam logic [7:0] HDR_SUM = byte_sum(HEADER);

  state_t              state, state_nxt;
  logic [HDR_W-1:0]    window;
  logic [FILL_W-1:0]   fill;
  logic [BODY_W-1:0]   body;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [7:0]          sum;
  logic [TO_W-1:0]     to_cnt;

  logic [HDR_W-1:0]    win_nxt_c;
  logic                hdr_match_c;
  logic                last_bit_c;
  logic                timeout_c;
  logic                byte_done_c;
  logic                chk_ok_c;
  logic                header_hit_c;
  logic                valid_hit_c;
  logic                err_hit_c;
  logic                to_hit_c;

  assign win_nxt_c   = {window[HDR_W-2:0], ser_i};
  assign hdr_match_c = (fill >= FILL_W'(HDR_W - 1)) && (win_nxt_c == HEADER);
  assign last_bit_c  = (bit_cnt == BCNT_W'(BODY_W - 1));
  assign timeout_c   = (TIMEOUT_CYC != 0) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign byte_done_c = (bit_cnt[2:0] == 3'b111) && (bit_cnt < BCNT_W'(PLD_W));
  assign chk_ok_c    = (body[7:0] == sum);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync_flag && hdr_match_c) state_nxt = COLLECT;
      COLLECT: begin
        if (sync_flag && last_bit_c)   state_nxt = CHECK;
        else if (!sync_flag && timeout_c) state_nxt = HUNT;
      end
      CHECK:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Status pulse decode; registered below
  always_comb begin
    header_hit_c = 1'b0;
    valid_hit_c  = 1'b0;
    err_hit_c    = 1'b0;
    to_hit_c     = 1'b0;
    case (state)
      HUNT:    header_hit_c = sync_flag && hdr_match_c;
      COLLECT: to_hit_c     = !sync_flag && timeout_c;
      CHECK: begin
        valid_hit_c = chk_ok_c;
        err_hit_c   = !chk_ok_c;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      window       <= '0;
      fill         <= '0;
      body         <= '0;
      bit_cnt      <= '0;
      sum          <= '0;
      to_cnt       <= '0;
      header_flag  <= 1'b0;
      valid_flag   <= 1'b0;
      chk_err      <= 1'b0;
      timeout_flag <= 1'b0;
      valid_data_o <= '0;
    end else begin
      header_flag  <= header_hit_c;
      valid_flag   <= valid_hit_c;
      chk_err      <= err_hit_c;
      timeout_flag <= to_hit_c;
      if (valid_hit_c) valid_data_o <= {HEADER, body};

      case (state)
        HUNT: begin
          if (sync_flag) begin
            if (hdr_match_c) begin
              window  <= '0;
              fill    <= '0;
              bit_cnt <= '0;
              sum     <= HDR_SUM;
              to_cnt  <= '0;
            end else begin
              window <= win_nxt_c;
              if (fill != FILL_W'(HDR_W)) fill <= fill + FILL_W'(1);
            end
          end
        end
        COLLECT: begin
          if (sync_flag) begin
            body    <= {body[BODY_W-2:0], ser_i};
            bit_cnt <= bit_cnt + BCNT_W'(1);
            to_cnt  <= '0;
            if (byte_done_c) sum <= sum + {body[6:0], ser_i};
          end else if (timeout_c) begin
            window <= '0;
            fill   <= '0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          window <= '0;
          fill   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  // Saturating frame statistics, updated alongside the status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (valid_hit_c && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if ((err_hit_c || to_hit_c) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_sync_detect.sv
// Directed bench for frame_sync_detect: default (8-bit header) and 16-bit header instances.
// Expected frame events are queued at stimulus time and popped as the DUTs report them.
module tb_frame_sync_detect;

  typedef struct packed {
    logic [2:0]  kind;   // 1 valid, 2 chk_err, 3 timeout, 5 valid16, 6 chk_err16
    logic [63:0] data;
    logic [31:0] lat;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_i, sync_flag, ser16, sync16;
  logic        header_flag, valid_flag, chk_err, timeout_flag;
  logic        header16, valid16, err16, timeout16;
  logic [39:0] valid_data_o;
  logic [31:0] valid_data16;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] good_cnt, err_cnt, good16, errc16;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc = 0, ls_cyc = 0, ls16_cyc = 0;
  int bits_sent = 0, hdr_cnt = 0, hdr_bits = 0, hdr16_cnt = 0, onehot_viol = 0;
  evt_t obs_q[$];
  evt_t exp_q[$];

  always #5 clk = ~clk;

  frame_sync_detect dut (
    .clk(clk), .rst(rst), .ser_i(ser_i), .sync_flag(sync_flag),
    .header_flag(header_flag), .valid_flag(valid_flag), .chk_err(chk_err),
    .timeout_flag(timeout_flag),
`ifdef FRAME_SYNC_STATS_EN
    .good_cnt(good_cnt), .err_cnt(err_cnt),
`endif
    .valid_data_o(valid_data_o)
  );

  frame_sync_detect #(.HDR_W(16), .HEADER(16'hEB90), .PLD_BYTES(1)) dut16 (
    .clk(clk), .rst(rst), .ser_i(ser16), .sync_flag(sync16),
    .header_flag(header16), .valid_flag(valid16), .chk_err(err16),
    .timeout_flag(timeout16),
`ifdef FRAME_SYNC_STATS_EN
    .good_cnt(good16), .err_cnt(errc16),
`endif
    .valid_data_o(valid_data16)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sync_flag) ls_cyc   <= cyc + 1;
    if (sync16)    ls16_cyc <= cyc + 1;
  end

  // Event monitor: records pulses away from the active edge
  always @(negedge clk) begin
    evt_t o;
    if ($countones({header_flag, valid_flag, chk_err, timeout_flag}) > 1) onehot_viol++;
    if ($countones({header16, valid16, err16, timeout16}) > 1) onehot_viol++;
    if (header_flag) begin hdr_cnt++; hdr_bits = bits_sent; end
    if (header16) hdr16_cnt++;
    o.data = 64'(valid_data_o);
    o.lat  = 32'(cyc - ls_cyc);
    if (valid_flag)   begin o.kind = 3'd1; obs_q.push_back(o); end
    if (chk_err)      begin o.kind = 3'd2; obs_q.push_back(o); end
    if (timeout_flag) begin o.kind = 3'd3; obs_q.push_back(o); end
    o.data = 64'(valid_data16);
    o.lat  = 32'(cyc - ls16_cyc);
    if (valid16)   begin o.kind = 3'd5; obs_q.push_back(o); end
    if (err16)     begin o.kind = 3'd6; obs_q.push_back(o); end
    if (timeout16) begin o.kind = 3'd7; obs_q.push_back(o); end
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b, input bit wide);
    @(negedge clk);
    if (wide) begin sync16 = 1'b1; ser16 = b; end
    else begin sync_flag = 1'b1; ser_i = b; bits_sent++; end
    @(negedge clk);
    sync_flag = 1'b0;
    sync16    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_vec(input logic [63:0] v, input int n, input bit wide);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], wide);
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [63:0] data, input int lat);
    evt_t e;
    e.kind = kind;
    e.data = data;
    e.lat  = 32'(lat);
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input string tag);
    int   n = 0;
    evt_t e, o;
    while (obs_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    chk({tag, "_seen"}, 64'(obs_q.size() != 0), 64'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      chk({tag, "_kind"}, 64'(o.kind), 64'(e.kind));
      chk({tag, "_data"}, o.data, e.data);
      chk({tag, "_lat"},  64'(o.lat), 64'(e.lat));
    end
  endtask

  initial begin
    int hb, bs;
    rst = 1'b1; sync_flag = 1'b0; ser_i = 1'b0; sync16 = 1'b0; ser16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_header", 64'(header_flag), 64'd0);
    chk("rst_valid",  64'(valid_flag), 64'd0);
    chk("rst_chkerr", 64'(chk_err), 64'd0);
    chk("rst_timeout", 64'(timeout_flag), 64'd0);
    chk("rst_data",   64'(valid_data_o), 64'd0);
    chk("rst_data16", 64'(valid_data16), 64'd0);

    // Bad checksum straight after reset keeps data at zero
    hb = hdr_cnt;
    push_exp(3'd2, 64'd0, 1);
    send_vec(64'hCC17181915, 40, 1'b0);
    check_evt("bad_first");
    chk("bad_first_hdr", 64'(hdr_cnt - hb), 64'd1);

    // Good frame
    hb = hdr_cnt; bs = bits_sent;
    push_exp(3'd1, 64'hCC17181914, 1);
    send_vec(64'hCC17181914, 40, 1'b0);
    check_evt("good");
    chk("good_hdr_cnt", 64'(hdr_cnt - hb), 64'd1);
    chk("good_hdr_bit", 64'(hdr_bits - bs), 64'd8);

    // Leading garbage, lock after bit 11
    hb = hdr_cnt; bs = bits_sent;
    push_exp(3'd1, 64'hCC17181914, 1);
    send_vec(64'b101, 3, 1'b0);
    send_vec(64'hCC17181914, 40, 1'b0);
    check_evt("garbage");
    chk("garbage_hdr_cnt", 64'(hdr_cnt - hb), 64'd1);
    chk("garbage_hdr_bit", 64'(hdr_bits - bs), 64'd11);

    // Stalled frame times out, then a new frame locks
    push_exp(3'd3, 64'hCC17181914, 64);
    send_vec(64'hCCA, 12, 1'b0);
    check_evt("timeout");
    push_exp(3'd1, 64'hCC010203D2, 1);
    send_vec(64'hCC010203D2, 40, 1'b0);
    check_evt("after_timeout");

    // 16-bit header instance
    push_exp(3'd5, 64'hEB90A520, 1);
    send_vec(64'hEB90A520, 32, 1'b1);
    check_evt("wide_good");
    push_exp(3'd6, 64'hEB90A520, 1);
    send_vec(64'hEB90A521, 32, 1'b1);
    check_evt("wide_bad");

    // Reset in the middle of a frame
    send_vec(64'hCC3F5, 18, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_header", 64'(header_flag), 64'd0);
    chk("midrst_valid",  64'(valid_flag), 64'd0);
    chk("midrst_timeout", 64'(timeout_flag), 64'd0);
    chk("midrst_data",   64'(valid_data_o), 64'd0);

    // Two good frames then one bad after reset
    push_exp(3'd1, 64'hCC17181914, 1);
    send_vec(64'hCC17181914, 40, 1'b0);
    check_evt("post_rst_good1");
    push_exp(3'd1, 64'hCC010203D2, 1);
    send_vec(64'hCC010203D2, 40, 1'b0);
    check_evt("post_rst_good2");
    push_exp(3'd2, 64'hCC010203D2, 1);
    send_vec(64'hCC17181915, 40, 1'b0);
    check_evt("post_rst_bad");
`ifdef FRAME_SYNC_STATS_EN
    chk("good_cnt", 64'(good_cnt), 64'd2);
    chk("err_cnt",  64'(err_cnt), 64'd1);
`endif

    repeat (100) @(negedge clk);
    chk("no_extra_events", 64'(obs_q.size()), 64'd0);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("pulses_exclusive", 64'(onehot_viol), 64'd0);
    chk("hdr16_cnt", 64'(hdr16_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
